// File: rtl/wall_map_renderer.sv
// Writable tile-map wall renderer: 2-stage pixel pipeline, occupancy query port,
// sequenced map clear and end-of-level colour flashing.
module wall_map_renderer #(
  parameter int          OFFSETH      = 130,
  parameter int          OFFSETV      = 24,
  parameter int          TILE_LOG2    = 3,
  parameter int          COLS         = 48,
  parameter int          ROWS         = 48,
  parameter logic [11:0] WALLCOLOR    = 12'h00F,
  parameter logic [11:0] FLASHCOLOR   = 12'hFFF,
  parameter int          FLASH_FRAMES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic        wallFill,
  input  logic        wr_en,
  input  logic [5:0]  wr_col,
  input  logic [5:0]  wr_row,
  input  logic        wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        q_req,
  input  logic [5:0]  q_col,
  input  logic [5:0]  q_row,
  output logic        q_ack,
  output logic        q_wall,
  input  logic        flash_en
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t          state, state_n;
  logic [RW-1:0]   row_ptr, row_ptr_n;
  logic [COLS-1:0] map_mem [ROWS];

  // Pixel stage 1
  logic [9:0]      h_off, v_off, col_full, row_full;
  logic            in_area_c;
  logic [COLS-1:0] word_c;
  logic            in_area_d1, bright_d1;
  logic [CW-1:0]   col_d1;
  logic [COLS-1:0] word_d1;
  logic            hit;
  logic [11:0]     colour;

  assign h_off     = hCount - 10'(OFFSETH);
  assign v_off     = vCount - 10'(OFFSETV);
  assign col_full  = h_off >> TILE_LOG2;
  assign row_full  = v_off >> TILE_LOG2;
  assign in_area_c = (hCount >= 10'(OFFSETH)) && (vCount >= 10'(OFFSETV)) &&
                     (col_full < 10'(COLS)) && (row_full < 10'(ROWS));
  assign word_c    = in_area_c ? map_mem[row_full[RW-1:0]] : '0;
  assign hit       = in_area_d1 & word_d1[col_d1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_area_d1 <= 1'b0;
      bright_d1  <= 1'b0;
      col_d1     <= '0;
      word_d1    <= '0;
      wallFill   <= 1'b0;
      rgb        <= '0;
    end else begin
      in_area_d1 <= in_area_c;
      bright_d1  <= bright;
      col_d1     <= col_full[CW-1:0];
      word_d1    <= word_c;
      wallFill   <= hit;
      rgb        <= (hit && bright_d1) ? colour : '0;
    end
  end

  // Flash: phase flips every FLASH_FRAMES frame ticks while enabled
  logic          frame_flag, frame_flag_d, frame_tick, phase;
  logic [FW-1:0] flash_cnt;

  assign frame_tick = frame_flag & ~frame_flag_d;
  assign colour     = phase ? FLASHCOLOR : WALLCOLOR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_flag   <= 1'b0;
      frame_flag_d <= 1'b0;
      flash_cnt    <= '0;
      phase        <= 1'b0;
    end else begin
      frame_flag   <= (hCount == 10'd0) && (vCount == 10'd0);
      frame_flag_d <= frame_flag;
      if (!flash_en) begin
        flash_cnt <= '0;
        phase     <= 1'b0;
      end else if (frame_tick) begin
        if (flash_cnt == FW'(FLASH_FRAMES - 1)) begin
          flash_cnt <= '0;
          phase     <= ~phase;
        end else begin
          flash_cnt <= flash_cnt + 1'b1;
        end
      end
    end
  end

  // Clear sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row_ptr <= '0;
    end else begin
      state   <= state_n;
      row_ptr <= row_ptr_n;
    end
  end

  always_comb begin
    state_n   = state;
    row_ptr_n = row_ptr;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = CLEAR;
          row_ptr_n = '0;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (row_ptr == RW'(ROWS - 1)) state_n = DONE;
        else row_ptr_n = row_ptr + 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Map writes: a start in IDLE or an active clear takes priority over wr_en
  logic wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_col} < 7'(COLS)) && ({1'b0, wr_row} < 7'(ROWS)) &&
                 (state != CLEAR) && !((state == IDLE) && start);

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) map_mem[row_ptr] <= '0;
      else if (wr_ok) map_mem[wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_data;
    end
  end

  // Occupancy query; out-of-range tiles read as wall
  logic accept, q_bit;
  assign accept = q_req && !busy && !q_ack;
  assign q_bit  = (({1'b0, q_col} < 7'(COLS)) && ({1'b0, q_row} < 7'(ROWS))) ?
                  map_mem[q_row[RW-1:0]][q_col[CW-1:0]] : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_ack  <= 1'b0;
      q_wall <= 1'b0;
    end else begin
      q_ack <= accept;
      if (accept) q_wall <= q_bit;
    end
  end
endmodule
